// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the 4:1 round-robin mux arbiter.
package mux_rr_arbiter_pkg;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // One-hot grant vector for a requester index.
  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_pick4.sv
// Combinational round-robin pick: first requester at or after ptr (mod 4).
module rr_pick4
  import mux_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan ptr, ptr+1, ptr+2, ptr+3 and keep the first hit.
  always_comb begin
    logic [IDX_W-1:0] cand;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter / sequencer for a 4:1 W-bit select mux with tenure cap.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int unsigned W        = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] din,
  output logic [NREQ-1:0]   gnt,
  output logic [IDX_W-1:0]  sel,
  output logic              busy,
  output logic [W-1:0]      dout
);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;
  logic [CNT_W-1:0] hold_cnt;

  logic [IDX_W-1:0] next_owner;
  logic [IDX_W-1:0] pick_ptr;
  logic [IDX_W-1:0] win;
  logic             found;
  logic             release_now;

  // Release when the owner lets go or its tenure hits the cap; on release the
  // scan starts just past the owner so the owner is considered last.
  always_comb begin
    next_owner  = owner + 2'd1;
    release_now = (state == OWN) &&
                  (!req[owner] || (hold_cnt == CNT_W'(MAX_HOLD)));
    pick_ptr    = (state == OWN) ? next_owner : ptr;
  end

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .idx   (win),
    .found (found)
  );

  // Arbitration state machine with registered grant, select, busy and data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      dout     <= '0;
    end else begin
      case (state)
        IDLE: begin
          dout <= '0;
          if (found) begin
            owner    <= win;
            gnt      <= onehot(win);
            sel      <= win;
            busy     <= 1'b1;
            hold_cnt <= CNT_W'(1);
            state    <= OWN;
          end
        end
        OWN: begin
          dout <= din[owner*W +: W];
          if (!release_now) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end else begin
            ptr <= next_owner;
            if (found) begin
              owner    <= win;
              gnt      <= onehot(win);
              sel      <= win;
              hold_cnt <= CNT_W'(1);
            end else begin
              gnt      <= '0;
              busy     <= 1'b0;
              hold_cnt <= '0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter (W=1, MAX_HOLD=4).
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic [0:0] dout;

  int checks = 0;
  int errors = 0;

  mux_rr_arbiter #(.W(1), .MAX_HOLD(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .din  (din),
    .gnt  (gnt),
    .sel  (sel),
    .busy (busy),
    .dout (dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] hold_exp [12];

  initial begin
    hold_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                 4'b0001, 4'b0001, 4'b0001, 4'b0001};

    // Reset state
    rst = 1'b1; req = '0; din = '0;
    step(); step();
    check("rst_gnt",  32'(gnt),  32'h0);
    check("rst_sel",  32'(sel),  32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_dout", 32'(dout), 32'h0);
    rst = 1'b0;
    step();
    check("idle_gnt", 32'(gnt), 32'h0);

    // Single request to lane 2
    req = 4'b0100; din = 4'b0100;
    step();
    check("single_gnt",   32'(gnt),  32'h4);
    check("single_sel",   32'(sel),  32'h2);
    check("single_busy",  32'(busy), 32'h1);
    check("single_dout0", 32'(dout), 32'h0);
    step();
    check("single_dout1", 32'(dout), 32'h1);
    check("single_hold",  32'(gnt),  32'h4);
    req = 4'b0000;
    step();
    check("drop2_gnt",  32'(gnt),  32'h0);
    check("drop2_busy", 32'(busy), 32'h0);
    check("drop2_sel",  32'(sel),  32'h2);
    check("drop2_ptr",  32'(dut.ptr), 32'h3);
    step();
    check("drop2_dout", 32'(dout), 32'h0);

    // Hold limit with two constant requesters, no bubbles
    req = 4'b0011; din = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("hold_gnt%0d", i), 32'(gnt), 32'(hold_exp[i]));
      check($sformatf("hold_busy%0d", i), 32'(busy), 32'h1);
    end
    req = 4'b0000;
    step();
    check("hold_end_gnt", 32'(gnt), 32'h0);

    // Sole requester at the hold limit re-wins with counter wrapping
    req = 4'b0001; din = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("sole_gnt%0d", k),  32'(gnt),  32'h1);
      check($sformatf("sole_busy%0d", k), 32'(busy), 32'h1);
      check($sformatf("sole_cnt%0d", k),  32'(dut.hold_cnt), 32'((k % 4) + 1));
    end
    req = 4'b0000;
    step();
    check("sole_end_gnt", 32'(gnt), 32'h0);
    step();

    // Asynchronous reset in the middle of a tenure of requester 2
    req = 4'b0100; din = 4'b0100;
    step();
    check("pre_rst_gnt", 32'(gnt), 32'h4);
    step();
    check("pre_rst_dout", 32'(dout), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_gnt",  32'(gnt),  32'h0);
    check("arst_sel",  32'(sel),  32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_dout", 32'(dout), 32'h0);
    req = 4'b1111;
    #1 rst = 1'b0;
    step();
    check("post_rst_gnt", 32'(gnt), 32'h1);
    check("post_rst_sel", 32'(sel), 32'h0);

    // Early release: requester 0 drops after 2 cycles, 3 takes over
    req = 4'b1001; din = 4'b1000;
    step();
    check("early_hold_gnt", 32'(gnt), 32'h1);
    req = 4'b1000;
    step();
    check("early_gnt", 32'(gnt), 32'h8);
    check("early_sel", 32'(sel), 32'h3);
    check("early_ptr", 32'(dut.ptr), 32'h1);

    // All drop while owner 3 is active
    req = 4'b0000;
    step();
    check("alldrop_gnt",  32'(gnt),  32'h0);
    check("alldrop_busy", 32'(busy), 32'h0);
    check("alldrop_sel",  32'(sel),  32'h3);
    check("alldrop_lastdout", 32'(dout), 32'h1);
    step();
    check("alldrop_dout", 32'(dout), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
